// File: rtl/k7_pkg.sv
// Shared types and constants for the cassette SDRAM scheduler.
package k7_pkg;

    localparam int unsigned K7_ADDR_W = 25;
    // Cycles after a request before sdram_ready may be taken as completion.
    localparam int unsigned K7_GUARD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrWait,
        StRdReq,
        StRdWait
    } k7_state_t;

endpackage

// File: rtl/k7_byte_fifo.sv
// First-word fall-through byte FIFO with a registered head, synchronous flush and occupancy count.
module k7_byte_fifo #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    data_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, remain;
    logic [7:0]    head_q, head_d;
    logic          push_ok, pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
    assign remain  = count_q - CW'(pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PW + 1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (PW + 1)'(pop_ok);
        count_d  = remain + CW'(push_ok);
        head_d   = head_q;
        // The pushed byte becomes the head only when nothing else is left in front of it.
        if (remain == '0) begin
            if (push_ok) head_d = data_i;
        end else begin
            head_d = mem_q[rd_ptr_d[PW-1:0]];
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
    end

    assign data_o  = head_q;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/k7_sdram_sched.sv
// Arbitrates the SDRAM byte port between HPS tape-image writes and playback prefetch reads,
// and owns play/pause, rewind and end-of-tape state.
module k7_sdram_sched
    import k7_pkg::*;
#(
    parameter int unsigned ADDR_W     = K7_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              play_toggle,
    input  logic              rewind,
    input  logic              byte_pop,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    output logic              playing,
    output logic              tape_end,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [7:0]        sdram_din,
    output logic              sdram_rd,
    output logic              sdram_we,
    input  logic [7:0]        sdram_dout,
    input  logic              sdram_ready
);
    localparam int unsigned   CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    k7_state_t         state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, addr_q, addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_pend_q, wr_pend_d, wait_q, wait_d;
    logic [ADDR_W:0]   tape_len_q, tape_len_d, rd_ptr_q, rd_ptr_d, wr_len, len_base;
    logic              playing_q, playing_d, tape_end_q, tape_end_d;
    logic              discard_q, discard_d, dl_q;
    logic [1:0]        guard_q, guard_d;
    logic [CW-1:0]     fifo_count;
    logic              dl_start, flush, done, rd_ok, eot, push;

    assign dl_start = ioctl_download & ~dl_q;
    assign flush    = rewind | dl_start;
    assign done     = ((state_q == StWrWait) || (state_q == StRdWait)) &&
                      (guard_q >= 2'(K7_GUARD)) && sdram_ready;
    assign rd_ok    = playing_q && !ioctl_download && !flush && !wr_pend_q &&
                      (rd_ptr_q < tape_len_q) && (fifo_count < FULL);
    assign eot      = playing_q && (rd_ptr_q == tape_len_q) && (fifo_count == '0) &&
                      (state_q != StRdWait);
    assign wr_len   = {1'b0, ioctl_addr} + (ADDR_W + 1)'(1);

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_pend_d = wr_pend_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        rd_ptr_d  = rd_ptr_q;
        guard_d   = guard_q;
        discard_d = discard_q;
        sdram_rd  = 1'b0;
        sdram_we  = 1'b0;
        push      = 1'b0;
        if (guard_q < 2'(K7_GUARD)) guard_d = guard_q + 2'd1;
        if (ioctl_wr && !wr_pend_q) begin
            wr_addr_d = ioctl_addr;
            wr_data_d = ioctl_dout;
            wr_pend_d = 1'b1;
            wait_d    = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (wr_pend_q) begin
                    state_d = StWrReq;
                    addr_d  = wr_addr_q;
                end else if (rd_ok) begin
                    state_d = StRdReq;
                    addr_d  = rd_ptr_q[ADDR_W-1:0];
                end
            end
            StWrReq: begin
                if (sdram_ready) begin
                    sdram_we = 1'b1;
                    guard_d  = 2'd1;
                    state_d  = StWrWait;
                end
            end
            StWrWait: begin
                if (done) begin
                    wr_pend_d = 1'b0;
                    wait_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            StRdReq: begin
                // Abandon an unissued read if a write, pause or flush got in first.
                if (!rd_ok) begin
                    state_d = StIdle;
                end else if (sdram_ready) begin
                    sdram_rd = 1'b1;
                    guard_d  = 2'd1;
                    rd_ptr_d = rd_ptr_q + (ADDR_W + 1)'(1);
                    state_d  = StRdWait;
                end
            end
            StRdWait: begin
                if (done) begin
                    push      = !discard_q && !flush;
                    discard_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            rd_ptr_d = '0;
            if ((state_q == StRdWait) && !done) discard_d = 1'b1;
        end
    end

    always_comb begin
        len_base   = dl_start ? '0 : tape_len_q;
        tape_len_d = len_base;
        if (ioctl_wr && !wr_pend_q && (wr_len > len_base)) tape_len_d = wr_len;
        playing_d  = playing_q;
        tape_end_d = tape_end_q;
        if (flush) begin
            playing_d  = 1'b0;
            tape_end_d = 1'b0;
        end else if (eot) begin
            playing_d  = 1'b0;
            tape_end_d = 1'b1;
        end else if (play_toggle && (tape_len_q != '0) && !ioctl_download) begin
            playing_d = !playing_q;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_pend_q  <= 1'b0;
            wait_q     <= 1'b0;
            addr_q     <= '0;
            rd_ptr_q   <= '0;
            tape_len_q <= '0;
            guard_q    <= '0;
            discard_q  <= 1'b0;
            playing_q  <= 1'b0;
            tape_end_q <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_pend_q  <= wr_pend_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            tape_len_q <= tape_len_d;
            guard_q    <= guard_d;
            discard_q  <= discard_d;
            playing_q  <= playing_d;
            tape_end_q <= tape_end_d;
            dl_q       <= ioctl_download;
        end
    end

    k7_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .flush_i(flush),
        .push_i (push),
        .data_i (sdram_dout),
        .pop_i  (byte_pop),
        .data_o (byte_data),
        .valid_o(byte_valid),
        .count_o(fifo_count)
    );

    assign ioctl_wait = ioctl_wr | wait_q;
    assign playing    = playing_q;
    assign tape_end   = tape_end_q;
    assign sdram_addr = addr_q;
    assign sdram_din  = wr_data_q;

endmodule

// File: tb/tb_k7_sdram_sched.sv
// Directed bench for k7_sdram_sched with a small behavioural SDRAM model.
module tb_k7_sdram_sched;
    localparam int unsigned AW = 25;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [AW:0]   len;
    } wr_vec_t;

    logic          clk_sys, reset_n;
    logic          ioctl_download, ioctl_wr, ioctl_wait;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          play_toggle, rewind, byte_pop;
    logic [7:0]    byte_data;
    logic          byte_valid, playing, tape_end;
    logic [AW-1:0] sdram_addr;
    logic [7:0]    sdram_din, sdram_dout;
    logic          sdram_rd, sdram_we, sdram_ready;

    int errors = 0;
    int checks = 0;

    // SDRAM model: busy for lat cycles after each request, data captured at the read pulse.
    int            lat = 3;
    int            busy = 0;
    int            we_cnt = 0;
    int            rd_cnt = 0;
    int            proto_err = 0;
    logic [7:0]    sd_mem [64];
    logic [7:0]    sd_q = '0;
    logic [AW-1:0] last_we_addr = '0;
    logic [7:0]    last_we_data = '0;
    logic [AW-1:0] rd_log [256];

    assign sdram_ready = (busy == 0);
    assign sdram_dout  = sd_q;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 0;
        end else begin
            if (busy != 0) busy <= busy - 1;
            if ((sdram_we || sdram_rd) && !sdram_ready) proto_err <= proto_err + 1;
            if (sdram_we) begin
                sd_mem[sdram_addr[5:0]] <= sdram_din;
                last_we_addr <= sdram_addr;
                last_we_data <= sdram_din;
                we_cnt <= we_cnt + 1;
                busy <= lat;
            end
            if (sdram_rd) begin
                sd_q <= sd_mem[sdram_addr[5:0]];
                rd_log[rd_cnt[7:0]] <= sdram_addr;
                rd_cnt <= rd_cnt + 1;
                busy <= lat;
            end
        end
    end

    k7_sdram_sched #(
        .ADDR_W(AW),
        .FIFO_DEPTH(8)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .play_toggle   (play_toggle),
        .rewind        (rewind),
        .byte_pop      (byte_pop),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .playing       (playing),
        .tape_end      (tape_end),
        .sdram_addr    (sdram_addr),
        .sdram_din     (sdram_din),
        .sdram_rd      (sdram_rd),
        .sdram_we      (sdram_we),
        .sdram_dout    (sdram_dout),
        .sdram_ready   (sdram_ready)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wait"}, 32'(ioctl_wait), 0);
        check({tag, "_playing"}, 32'(playing), 0);
        check({tag, "_tape_end"}, 32'(tape_end), 0);
        check({tag, "_valid"}, 32'(byte_valid), 0);
        check({tag, "_data"}, 32'(byte_data), 0);
        check({tag, "_rd"}, 32'(sdram_rd), 0);
        check({tag, "_we"}, 32'(sdram_we), 0);
        check({tag, "_addr"}, 32'(sdram_addr), 0);
        check({tag, "_din"}, 32'(sdram_din), 0);
        check({tag, "_tape_len"}, 32'(dut.tape_len_q), 0);
        check({tag, "_rd_ptr"}, 32'(dut.rd_ptr_q), 0);
    endtask

    task automatic hps_write(input logic [AW-1:0] a, input logic [7:0] d, input logic [AW:0] len);
        int n;
        int we0;
        we0 = we_cnt;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        #1;
        check("wr_wait_comb", 32'(ioctl_wait), 1);
        tick(1);
        ioctl_wr = 1'b0;
        n = 1;
        while (ioctl_wait && n < 60) begin
            tick(1);
            n++;
        end
        check("wr_wait_span", 32'(n >= 5 && n < 60), 1);
        check("wr_we_count", 32'(we_cnt - we0), 1);
        check("wr_we_addr", 32'(last_we_addr), 32'(a));
        check("wr_we_data", 32'(last_we_data), 32'(d));
        check("wr_tape_len", 32'(dut.tape_len_q), 32'(len));
    endtask

    task automatic play_all(input logic [7:0] exp [8], input int num, input string tag);
        int got;
        int n;
        int rd0;
        rd0 = rd_cnt;
        got = 0;
        n = 0;
        byte_pop = 1'b1;
        play_toggle = 1'b1;
        tick(1);
        play_toggle = 1'b0;
        while (!tape_end && n < 300) begin
            if (byte_valid) begin
                if (got < num) check($sformatf("%s_byte%0d", tag, got), 32'(byte_data), 32'(exp[got]));
                got++;
            end
            tick(1);
            n++;
        end
        byte_pop = 1'b0;
        check({tag, "_count"}, 32'(got), 32'(num));
        check({tag, "_tape_end"}, 32'(tape_end), 1);
        check({tag, "_playing"}, 32'(playing), 0);
        tick(20);
        check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(num));
    endtask

    initial begin
        wr_vec_t    img_a [3];
        wr_vec_t    img_b [5];
        logic [7:0] exp_a [8];
        logic [7:0] exp_b [8];
        int         n;
        int         rd0;
        int         rd1;

        img_a[0] = '{25'd0, 8'h11, 26'd1};
        img_a[1] = '{25'd1, 8'h22, 26'd2};
        img_a[2] = '{25'd2, 8'h33, 26'd3};
        img_b[0] = '{25'd4, 8'hA4, 26'd5};
        img_b[1] = '{25'd0, 8'hA0, 26'd5};
        img_b[2] = '{25'd1, 8'hA1, 26'd5};
        img_b[3] = '{25'd2, 8'hA2, 26'd5};
        img_b[4] = '{25'd3, 8'hA3, 26'd5};
        exp_a = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00, 8'h00};

        reset_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        play_toggle = 1'b0;
        rewind = 1'b0;
        byte_pop = 1'b0;
        #3;
        check_reset("rst");
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Empty tape: play_toggle is ignored.
        play_toggle = 1'b1;
        tick(1);
        play_toggle = 1'b0;
        tick(3);
        check("empty_play", 32'(playing), 0);

        ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) hps_write(img_a[i].addr, img_a[i].data, img_a[i].len);
        ioctl_download = 1'b0;
        tick(2);
        play_all(exp_a, 3, "pa");

        // 20-byte image, byte i = 0x11*(i+1); consumer stalled.
        ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 20; i++) hps_write(AW'(i), 8'((i + 1) * 17), (AW + 1)'(i + 1));
        ioctl_download = 1'b0;
        tick(2);
        rd0 = rd_cnt;
        play_toggle = 1'b1;
        tick(1);
        play_toggle = 1'b0;
        tick(150);
        check("bp_reads", 32'(rd_cnt - rd0), 8);
        check("bp_rd_ptr", 32'(dut.rd_ptr_q), 8);
        check("bp_valid", 32'(byte_valid), 1);
        check("bp_head", 32'(byte_data), 32'h11);
        byte_pop = 1'b1;
        tick(1);
        byte_pop = 1'b0;
        tick(40);
        check("bp_reads_pop", 32'(rd_cnt - rd0), 9);
        check("bp_rd_ptr_pop", 32'(dut.rd_ptr_q), 9);
        check("bp_head_pop", 32'(byte_data), 32'h22);

        // Rewind while a read is outstanding.
        byte_pop = 1'b1;
        tick(1);
        byte_pop = 1'b0;
        n = 0;
        while (!sdram_rd && n < 30) begin
            tick(1);
            n++;
        end
        check("rw_issue_seen", 32'(sdram_rd), 1);
        rd1 = rd_cnt;
        tick(1);
        rewind = 1'b1;
        tick(1);
        rewind = 1'b0;
        tick(15);
        check("rw_valid", 32'(byte_valid), 0);
        check("rw_playing", 32'(playing), 0);
        check("rw_tape_end", 32'(tape_end), 0);
        check("rw_rd_ptr", 32'(dut.rd_ptr_q), 0);
        check("rw_reads", 32'(rd_cnt - rd1), 1);
        rd1 = rd_cnt;
        play_toggle = 1'b1;
        tick(1);
        play_toggle = 1'b0;
        n = 0;
        while (!byte_valid && n < 40) begin
            tick(1);
            n++;
        end
        check("rw_restart_data", 32'(byte_data), 32'h11);
        check("rw_restart_addr", 32'(rd_log[rd1 % 256]), 0);

        // New download in the middle of playback.
        tick(5);
        rd0 = rd_cnt;
        ioctl_download = 1'b1;
        tick(1);
        check("dp_playing", 32'(playing), 0);
        tick(8);
        check("dp_valid", 32'(byte_valid), 0);
        for (int i = 0; i < 5; i++) hps_write(img_b[i].addr, img_b[i].data, img_b[i].len);
        tick(10);
        check("dp_no_read", 32'(rd_cnt - rd0), 0);
        ioctl_download = 1'b0;
        tick(2);
        check("dp_tape_len", 32'(dut.tape_len_q), 5);
        play_all(exp_b, 5, "pb");

        // Asynchronous reset while a write is outstanding.
        ioctl_download = 1'b1;
        tick(1);
        ioctl_addr = 25'd7;
        ioctl_dout = 8'h5A;
        ioctl_wr = 1'b1;
        tick(1);
        ioctl_wr = 1'b0;
        n = 0;
        while (!sdram_we && n < 20) begin
            tick(1);
            n++;
        end
        check("rs_we_seen", 32'(sdram_we), 1);
        tick(1);
        check("rs_wait_pre", 32'(ioctl_wait), 1);
        #2;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        check_reset("rs");
        tick(2);
        reset_n = 1'b1;
        tick(2);
        rd0 = rd_cnt;
        play_toggle = 1'b1;
        tick(1);
        play_toggle = 1'b0;
        tick(5);
        check("rs_play_empty", 32'(playing), 0);
        check("rs_no_read", 32'(rd_cnt - rd0), 0);

        check("sdram_protocol", 32'(proto_err), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/k7_sdram_sched.md
# k7_sdram_sched

Schedules the single shared SDRAM byte port between HPS tape-image download (ioctl writes) and tape playback reads. Image bytes are written to SDRAM from address 0. On play, the block prefetches them sequentially into a small FWFT FIFO that the cassette bit-serializer drains. It sits between `hps_io`/`sdram` and the cassette modulator in the emu top level, and also owns play/pause, rewind and end-of-tape state.

## Interface
Parameters:
- `ADDR_W`, 25: SDRAM byte address width.
- `FIFO_DEPTH`, 8: prefetch depth; must be a power of 2 and at least 2.

Ports:
- `clk_sys` in 1: system clock. One clock domain only.
- `reset_n` in 1: asynchronous reset, active low.
- `ioctl_download` in 1: download in progress.
- `ioctl_wr` in 1: one-cycle write strobe.
- `ioctl_addr` in ADDR_W: write address.
- `ioctl_dout` in 8: write data.
- `ioctl_wait` out 1: stalls the HPS while a write is pending.
- `play_toggle` in 1: one-cycle pulse; toggles play/pause.
- `rewind` in 1: one-cycle pulse.
- `byte_pop` in 1: consumer takes `byte_data`.
- `byte_data` out 8: FIFO head (first-word fall-through).
- `byte_valid` out 1: FIFO not empty.
- `playing` out 1: playback active.
- `tape_end` out 1: all bytes delivered.
- `sdram_addr` out ADDR_W: address to SDRAM.
- `sdram_din` out 8: write data to SDRAM.
- `sdram_rd` out 1: one-cycle read request.
- `sdram_we` out 1: one-cycle write request.
- `sdram_dout` in 8: read data from SDRAM.
- `sdram_ready` in 1: SDRAM idle / previous request complete.

## Operation
FSM states are IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.

- **Priority:** a download write always beats a read. A read is never started while `ioctl_download`=1.
- **Write path:**
  - `ioctl_wr` latches address and data, and raises `ioctl_wait` in the same cycle (combinational from `ioctl_wr`, then registered).
  - IDLE→WR_REQ. The block issues `sdram_we` when `sdram_ready`=1, then goes to WR_WAIT.
  - When `sdram_ready` returns, `ioctl_wait` drops and the FSM returns to IDLE.
- **Length capture:** `tape_len` is an ADDR_W+1-bit register.
  - It is cleared on the rising edge of `ioctl_download`.
  - Each write sets `tape_len = max(tape_len, ioctl_addr+1)`.
- **Download start:** forces `playing`=0, `tape_end`=0, flushes the FIFO and sets `rd_ptr`=0.
- **Read scheduling:** the block issues a read when all of the following hold: `playing`=1, `rd_ptr` < `tape_len`, a free FIFO slot exists, and the state is IDLE.
  - Only one read may be in flight. The free slot is reserved at issue.
  - Data is pushed on the completion cycle, and `rd_ptr` is incremented at issue.
- **play_toggle:** ignored if `tape_len`=0 or a download is active. Otherwise it toggles `playing`. Pausing does not flush the FIFO.
- **rewind:** sets `playing`=0, flushes the FIFO, sets `rd_ptr`=0 and clears `tape_end`.
  - If a read is in flight, the FSM still waits for completion and discards that byte (a discard flag is set).
- **End of tape:** when `rd_ptr`=`tape_len`, the FIFO is empty and no read is in flight while `playing`, the block sets `tape_end`=1 and `playing`=0.
- **Simultaneous pulses:** `rewind` wins over `play_toggle` in the same cycle. `byte_pop` with `byte_valid`=0 is ignored.

## Timing
- **Reset values:** `ioctl_wait`=0, `playing`=0, `tape_end`=0, `byte_valid`=0, `byte_data`=0, `sdram_rd`=0, `sdram_we`=0, `sdram_addr`=0, `sdram_din`=0, `tape_len`=0, `rd_ptr`=0. FSM is in IDLE.
- **SDRAM handshake:**
  - A request is a one-cycle pulse, only while `sdram_ready`=1.
  - Completion is the first cycle with `sdram_ready`=1 at least two cycles after the pulse.
  - `sdram_dout` is sampled on that completion cycle.
- **Read latency:** the byte becomes visible (`byte_valid`) one cycle after the completion cycle.
- **Issue rate:** back-to-back requests need at least one IDLE cycle between completion and the next request.
- **FIFO push/pop:** allowed in the same cycle, including when full or empty+push. The FIFO occupancy count never wraps.
- **Reset mid-transfer:** asynchronous; drops any request immediately. The SDRAM controller is re-initialised by the top level.

## Structure
- **Package `k7_pkg`:** state enum `k7_state_t`, `ADDR_W` default, completion guard constant (2).
- **Sub-module `k7_byte_fifo`:**
  - Parameterised FWFT FIFO with synchronous flush, `count` output and registered head.
  - Depth FIFO_DEPTH, pointers log2(FIFO_DEPTH)+1 bits.
- **Scheduler top:** FSM, pointers, length tracking and control pulses live in the top module.

## Test plan
- **Download:** write bytes 0x11,0x22,0x33 to addrs 0..2, with the SDRAM model holding `ready` low 3 cycles per write → three `sdram_we` pulses at addrs 0,1,2; `ioctl_wait` high until each completes; `tape_len`=3.
- **Playback:** `play_toggle` then continuous `byte_pop` → `byte_data` sequence 0x11,0x22,0x33; then `tape_end`=1 and `playing`=0, with no 4th read.
- **Backpressure:** 20-byte tape, FIFO_DEPTH=8, no pops → exactly 8 reads issued, `rd_ptr`=8; pop 1 → exactly one further read.
- **Rewind in flight:** `rewind` while RD_WAIT → the in-flight byte is discarded, `byte_valid`=0, next play restarts at addr 0 returning 0x11.
- **Download during play:** assert `ioctl_download` mid-playback → `playing` drops, FIFO flushed, no `sdram_rd` until the download ends; new `tape_len` reflects the new image.
- **Asynchronous reset** during WR_WAIT → all outputs at their reset values the same cycle; `play_toggle` with `tape_len`=0 → `playing` stays 0.
